bfp_block_decoder: RTL and testbench

- Streaming block-floating-point (BFP) decoder for the ECG compression path.
- It is the receive-side counterpart of the leading-zero-based normaliser: it takes a header word with a shared shift (the encoder's leading-zero-derived exponent) and a block length, then expands each following mantissa back to a full-width signed ECG sample.
- It sits between the compressed-stream FIFO and the sample-processing pipeline.
- Both sides use valid/ready handshakes.

---
 rtl/bfp_pkg.sv | 20 ++
 rtl/bfp_expand.sv | 27 ++
 rtl/bfp_block_decoder.sv | 114 +++++++++++
 tb/tb_bfp_block_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfp_pkg.sv
// Shared definitions for the BFP encoder/decoder pair: FSM states, header
// field layout and default widths.
package bfp_pkg;

    localparam int unsigned DEF_MANT_W    = 8;
    localparam int unsigned DEF_OUT_W     = 16;
    localparam int unsigned DEF_MAX_SHIFT = DEF_OUT_W - DEF_MANT_W;

    // Header word layout: [7:4] = block length minus one, [3:0] = shift
    localparam int unsigned SHIFT_LSB = 0;
    localparam int unsigned SHIFT_W   = 4;
    localparam int unsigned LEN_LSB   = 4;
    localparam int unsigned LEN_W     = 4;

    typedef enum logic {
        S_HDR,
        S_DATA
    } bfp_state_e;

endpackage

// File: rtl/bfp_expand.sv
// Combinational mantissa expansion: sign-extend and left-shift by the block
// exponent; BFP_DEC_ROUND_EN fills the discarded LSBs with a half-step.
module bfp_expand
    import bfp_pkg::*;
#(
    parameter int unsigned MANT_W = DEF_MANT_W,
    parameter int unsigned OUT_W  = DEF_OUT_W
) (
    input  logic [MANT_W-1:0]  m,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   sample
);

    logic [OUT_W-1:0] ext;

    always_comb begin
        ext    = {{(OUT_W - MANT_W){m[MANT_W-1]}}, m};
        sample = ext << shift;
`ifdef BFP_DEC_ROUND_EN
        // Shifted-in bits are zero, so OR-ing the midpoint equals adding it
        if (shift != '0) begin
            sample = sample | (OUT_W'(1) << (shift - SHIFT_W'(1)));
        end
`endif
    end

endmodule

// File: rtl/bfp_block_decoder.sv
// Streaming block-floating-point decoder: header word (shift, length) followed
// by mantissas expanded to full-width samples. Optional macro: BFP_DEC_ROUND_EN.
module bfp_block_decoder
    import bfp_pkg::*;
#(
    parameter int unsigned MANT_W    = DEF_MANT_W,
    parameter int unsigned OUT_W     = DEF_OUT_W,
    parameter int unsigned MAX_SHIFT = DEF_MAX_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sample,
    output logic              out_last,
    output logic              err_shift,
    output logic [15:0]       block_cnt
);

    localparam logic [SHIFT_W-1:0] MAX_SHIFT_L = SHIFT_W'(MAX_SHIFT);

    bfp_state_e         state, state_next;
    logic [SHIFT_W-1:0] shift_q;
    logic [LEN_W-1:0]   rem_q;

    logic [SHIFT_W-1:0] hdr_shift;
    logic [LEN_W-1:0]   hdr_len;
    logic               shift_over;
    logic               hdr_acc;
    logic               dat_acc;
    logic               last_word;
    logic [OUT_W-1:0]   expanded;

    assign hdr_shift  = in_data[SHIFT_LSB +: SHIFT_W];
    assign hdr_len    = in_data[LEN_LSB +: LEN_W];
    assign shift_over = (hdr_shift > MAX_SHIFT_L);
    assign last_word  = (rem_q == '0);

    // Header needs no output slot; mantissas need the output register free
    always_comb begin
        in_ready = 1'b0;
        if (!abort) begin
            if (state == S_HDR) in_ready = 1'b1;
            else                in_ready = !out_valid || out_ready;
        end
    end

    assign hdr_acc = in_valid && in_ready && (state == S_HDR);
    assign dat_acc = in_valid && in_ready && (state == S_DATA);

    bfp_expand #(
        .MANT_W (MANT_W),
        .OUT_W  (OUT_W)
    ) u_expand (
        .m      (in_data),
        .shift  (shift_q),
        .sample (expanded)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HDR;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_HDR;
        end else begin
            case (state)
                S_HDR:   if (hdr_acc) state_next = S_DATA;
                S_DATA:  if (dat_acc && last_word) state_next = S_HDR;
                default: state_next = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            rem_q      <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_last   <= 1'b0;
            err_shift  <= 1'b0;
            block_cnt  <= '0;
        end else begin
            err_shift <= hdr_acc && shift_over;
            if (abort) begin
                rem_q     <= '0;
                out_valid <= 1'b0;
            end else begin
                if (hdr_acc) begin
                    shift_q <= shift_over ? MAX_SHIFT_L : hdr_shift;
                    rem_q   <= hdr_len;
                end
                if (dat_acc) begin
                    out_valid  <= 1'b1;
                    out_sample <= expanded;
                    out_last   <= last_word;
                    if (last_word) block_cnt <= block_cnt + 16'd1;
                    else           rem_q     <= rem_q - LEN_W'(1);
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bfp_block_decoder.sv
// Self-checking bench for bfp_block_decoder: vector table plus hand sequences,
// with a scoreboard queue checked as samples leave the decoder.
module tb_bfp_block_decoder;

`ifdef BFP_DEC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;
    logic        out_last;
    logic        err_shift;
    logic [15:0] block_cnt;

    always #5 clk = ~clk;

    bfp_block_decoder #(
        .MANT_W    (8),
        .OUT_W     (16),
        .MAX_SHIFT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_last   (out_last),
        .err_shift  (err_shift),
        .block_cnt  (block_cnt)
    );

    typedef struct {
        logic [15:0] sample;
        logic        last;
    } exp_t;

    typedef struct {
        logic [7:0]  mant;
        logic [3:0]  shift;
        logic [15:0] exp_trunc;
        logic [15:0] exp_rnd;
        logic        err;
    } vec_t;

    exp_t        q[$];
    exp_t        mon_e;
    vec_t        vecs[10];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] model_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] trunc, input logic [15:0] rnd, input logic last);
        exp_t e;
        e.sample = RND ? rnd : trunc;
        e.last   = last;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && !abort && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sample: got %h required none", out_sample);
            end else begin
                mon_e = q.pop_front();
                check("sample", {16'h0, out_sample}, {16'h0, mon_e.sample});
                check("last", {31'h0, out_last}, {31'h0, mon_e.last});
            end
        end
    end

    // Entered and left at posedge+#1; pushes the expectation on acceptance
    task automatic send_word(input logic [7:0] w, input bit is_data, input exp_t e);
        int unsigned cyc = 0;
        bit ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        while (!ok && cyc < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else          cyc++;
        end
        if (ok && is_data) q.push_back(e);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 required 1 for word %h", w);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            @(posedge clk);
            cyc++;
        end
        #1 check("drain", q.size(), 0);
    endtask

    exp_t none;

    initial begin
        none = mk(16'h0, 16'h0, 1'b0);
        vecs[0] = '{8'h01, 4'd0,  16'h0001, 16'h0001, 1'b0};
        vecs[1] = '{8'hFF, 4'd0,  16'hFFFF, 16'hFFFF, 1'b0};
        vecs[2] = '{8'h7F, 4'd8,  16'h7F00, 16'h7F80, 1'b0};
        vecs[3] = '{8'h80, 4'd8,  16'h8000, 16'h8080, 1'b0};
        vecs[4] = '{8'h01, 4'd2,  16'h0004, 16'h0006, 1'b0};
        vecs[5] = '{8'hFF, 4'd4,  16'hFFF0, 16'hFFF8, 1'b0};
        vecs[6] = '{8'h55, 4'd1,  16'h00AA, 16'h00AB, 1'b0};
        vecs[7] = '{8'hC3, 4'd5,  16'hF860, 16'hF870, 1'b0};
        vecs[8] = '{8'h40, 4'd15, 16'h4000, 16'h4080, 1'b1};
        vecs[9] = '{8'h00, 4'd7,  16'h0000, 16'h0040, 1'b0};

        rst_n     = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        model_cnt = 16'h0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 0);
        check("rst_out_sample", {16'h0, out_sample}, 0);
        check("rst_out_last", {31'h0, out_last}, 0);
        check("rst_err_shift", {31'h0, err_shift}, 0);
        check("rst_block_cnt", {16'h0, block_cnt}, 0);
        check("rst_in_ready", {31'h0, in_ready}, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-sample blocks covering sign, shift range and clamping
        for (int i = 0; i < 10; i++) begin
            send_word({4'h0, vecs[i].shift}, 1'b0, none);
            check("err_pulse", {31'h0, err_shift}, {31'h0, vecs[i].err});
            send_word(vecs[i].mant, 1'b1, mk(vecs[i].exp_trunc, vecs[i].exp_rnd, 1'b1));
            check("err_one_cycle", {31'h0, err_shift}, 0);
            model_cnt++;
        end
        drain();
        check("block_cnt_vec", {16'h0, block_cnt}, {16'h0, model_cnt});

        // Three-sample block, back to back
        send_word(8'h23, 1'b0, none);
        check("err_0x23", {31'h0, err_shift}, 0);
        send_word(8'h01, 1'b1, mk(16'h0008, 16'h000C, 1'b0));
        send_word(8'h7F, 1'b1, mk(16'h03F8, 16'h03FC, 1'b0));
        send_word(8'h80, 1'b1, mk(16'hFC00, 16'hFC04, 1'b1));
        model_cnt++;
        drain();
        check("block_cnt_3", {16'h0, block_cnt}, {16'h0, model_cnt});

        // Backpressure: held output, no input accepted, nothing lost
        out_ready = 1'b0;
        send_word(8'h30, 1'b0, none);
        send_word(8'h11, 1'b1, mk(16'h0011, 16'h0011, 1'b0));
        in_data  = 8'h22;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'h0, in_ready}, 0);
            check("stall_valid", {31'h0, out_valid}, 1);
            check("stall_sample", {16'h0, out_sample}, 32'h0011);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send_word(8'h22, 1'b1, mk(16'h0022, 16'h0022, 1'b0));
        send_word(8'h33, 1'b1, mk(16'h0033, 16'h0033, 1'b0));
        send_word(8'h44, 1'b1, mk(16'h0044, 16'h0044, 1'b1));
        model_cnt++;
        drain();
        check("block_cnt_stall", {16'h0, block_cnt}, {16'h0, model_cnt});

        // Abort after 2 of 4 mantissas; following word must be a header
        send_word(8'h31, 1'b0, none);
        send_word(8'h05, 1'b1, mk(16'h000A, 16'h000B, 1'b0));
        send_word(8'h06, 1'b1, mk(16'h000C, 16'h000D, 1'b0));
        out_ready = 1'b0;
        abort     = 1'b1;
        in_data   = 8'h99;
        in_valid  = 1'b1;
        @(negedge clk);
        check("abort_in_ready", {31'h0, in_ready}, 0);
        q.delete();
        @(posedge clk);
        #1;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("abort_out_valid", {31'h0, out_valid}, 0);
        check("abort_no_err", {31'h0, err_shift}, 0);
        send_word(8'h01, 1'b0, none);
        check("abort_hdr_err", {31'h0, err_shift}, 0);
        send_word(8'h03, 1'b1, mk(16'h0006, 16'h0007, 1'b1));
        model_cnt++;
        drain();
        check("block_cnt_abort", {16'h0, block_cnt}, {16'h0, model_cnt});

        // Reset in the middle of a block with a sample held
        out_ready = 1'b0;
        send_word(8'h32, 1'b0, none);
        send_word(8'h01, 1'b1, mk(16'h0004, 16'h0006, 1'b0));
        check("pre_rst_valid", {31'h0, out_valid}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'h0, out_valid}, 0);
        check("mid_rst_out_sample", {16'h0, out_sample}, 0);
        check("mid_rst_out_last", {31'h0, out_last}, 0);
        check("mid_rst_err", {31'h0, err_shift}, 0);
        check("mid_rst_block_cnt", {16'h0, block_cnt}, 0);
        check("mid_rst_in_ready", {31'h0, in_ready}, 1);
        q.delete();
        model_cnt = 16'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        // Counter wrap from 0xFFFF
        force dut.block_cnt = 16'hFFFF;
        @(posedge clk);
        #1 release dut.block_cnt;
        model_cnt = 16'hFFFF;
        check("preload_cnt", {16'h0, block_cnt}, {16'h0, model_cnt});
        send_word(8'h00, 1'b0, none);
        send_word(8'h7E, 1'b1, mk(16'h007E, 16'h007E, 1'b1));
        model_cnt++;
        drain();
        check("block_cnt_wrap", {16'h0, block_cnt}, {16'h0, model_cnt});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test required finish before 100000");
        $fatal(1);
    end

endmodule
